// File: rtl/nv_nvdla_core_soft_reset_seq.sv
// Soft-reset sequencer for the NVDLA core: drains the datapath, pulses core_reset_rstn
// low for a programmed length, then waits for the synchronized reset to cycle.
module nv_nvdla_core_soft_reset_seq #(
    parameter int unsigned LEN_W         = 8,
    parameter int unsigned MIN_ASSERT    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 4095,
    parameter int unsigned TO_W          = 12
) (
    input  logic             nvdla_clk,
    input  logic             dla_reset_rstn,
    input  logic             soft_rst_req,
    input  logic [LEN_W-1:0] soft_rst_len,
    input  logic             drain_ack,
    input  logic             synced_rstn,
    input  logic             timeout_clr,
    output logic             drain_req,
    output logic             core_reset_rstn,
    output logic             soft_rst_busy,
    output logic             soft_rst_done,
    output logic             drain_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ASSERT,
        S_RELEASE,
        S_DONE
    } state_e;

    localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_ASSERT);
    localparam logic [TO_W-1:0]  DRAIN_LAST = TO_W'(DRAIN_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] assert_cnt_q, assert_cnt_d;
    logic [TO_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic             seen_low_q, seen_low_d;
    logic             drain_req_q, drain_req_d;
    logic             core_rstn_q, core_rstn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             timeout_set;

    // State and registered outputs; core_reset_rstn idles high since dla reset already holds the core
    always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            assert_cnt_q <= '0;
            drain_cnt_q  <= '0;
            seen_low_q   <= 1'b0;
            drain_req_q  <= 1'b0;
            core_rstn_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            assert_cnt_q <= assert_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            seen_low_q   <= seen_low_d;
            drain_req_q  <= drain_req_d;
            core_rstn_q  <= core_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        assert_cnt_d = assert_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        seen_low_d   = seen_low_q;
        drain_req_d  = drain_req_q;
        core_rstn_d  = core_rstn_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (soft_rst_req) begin
                    len_d       = (soft_rst_len < MIN_LEN) ? MIN_LEN : soft_rst_len;
                    drain_cnt_d = '0;
                    seen_low_d  = 1'b0;
                    drain_req_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + TO_W'(1);
                // ack has priority over the timeout on the same edge
                if (drain_ack || (drain_cnt_q == DRAIN_LAST)) begin
                    timeout_set  = ~drain_ack;
                    drain_req_d  = 1'b0;
                    core_rstn_d  = 1'b0;
                    assert_cnt_d = len_q;
                    state_d      = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (!synced_rstn) begin
                    seen_low_d = 1'b1;
                end
                if (assert_cnt_q == LEN_W'(1)) begin
                    assert_cnt_d = '0;
                    core_rstn_d  = 1'b1;
                    state_d      = S_RELEASE;
                end else begin
                    assert_cnt_d = assert_cnt_q - LEN_W'(1);
                end
            end
            S_RELEASE: begin
                if (!synced_rstn) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && synced_rstn) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        timeout_d = timeout_set | (timeout_q & ~timeout_clr);
    end

    assign drain_req       = drain_req_q;
    assign core_reset_rstn = core_rstn_q;
    assign soft_rst_busy   = busy_q;
    assign soft_rst_done   = done_q;
    assign drain_timeout   = timeout_q;

endmodule

// File: tb/tb_nv_nvdla_core_soft_reset_seq.sv
// Scoreboard bench: each accepted request pushes its expected drain/low/busy lengths,
// and a monitor measures them and compares on every done pulse.
module tb_nv_nvdla_core_soft_reset_seq;

    localparam int unsigned LEN_W  = 8;
    localparam int          DTO    = 16;
    localparam int          MINA   = 4;
    localparam int          SYNC_D = 6;

    logic             nvdla_clk;
    logic             dla_reset_rstn;
    logic             soft_rst_req;
    logic [LEN_W-1:0] soft_rst_len;
    logic             drain_ack;
    logic             synced_rstn;
    logic             timeout_clr;
    logic             drain_req;
    logic             core_reset_rstn;
    logic             soft_rst_busy;
    logic             soft_rst_done;
    logic             drain_timeout;

    nv_nvdla_core_soft_reset_seq #(
        .LEN_W        (LEN_W),
        .MIN_ASSERT   (MINA),
        .DRAIN_TIMEOUT(DTO),
        .TO_W         (12)
    ) dut (
        .nvdla_clk      (nvdla_clk),
        .dla_reset_rstn (dla_reset_rstn),
        .soft_rst_req   (soft_rst_req),
        .soft_rst_len   (soft_rst_len),
        .drain_ack      (drain_ack),
        .synced_rstn    (synced_rstn),
        .timeout_clr    (timeout_clr),
        .drain_req      (drain_req),
        .core_reset_rstn(core_reset_rstn),
        .soft_rst_busy  (soft_rst_busy),
        .soft_rst_done  (soft_rst_done),
        .drain_timeout  (drain_timeout)
    );

    initial nvdla_clk = 1'b0;
    always #5 nvdla_clk = ~nvdla_clk;

    // Downstream synchronizer model: core_reset_rstn delayed by SYNC_D cycles on both edges
    logic [SYNC_D-1:0] sync_sr;
    always @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) sync_sr <= '1;
        else                 sync_sr <= {sync_sr[SYNC_D-2:0], core_reset_rstn};
    end
    assign synced_rstn = sync_sr[SYNC_D-1];

    typedef struct {
        int drain;
        int low;
        int busy;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   to_model = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: measure per-sequence lengths, compare against the scoreboard on each done
    initial begin
        int m_drain, m_low, m_busy;
        exp_t e;
        m_drain = 0; m_low = 0; m_busy = 0;
        forever begin
            @(negedge nvdla_clk);
            if (!dla_reset_rstn) begin
                m_drain = 0; m_low = 0; m_busy = 0;
            end else begin
                if (drain_req)        m_drain++;
                if (!core_reset_rstn) m_low++;
                if (soft_rst_busy)    m_busy++;
                if (soft_rst_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("drain_req_cycles", m_drain, e.drain);
                        check("core_rstn_low_cycles", m_low, e.low);
                        check("busy_cycles", m_busy, e.busy);
                        check("busy_at_done", int'(soft_rst_busy), 0);
                        check("timeout_at_done", int'(drain_timeout), int'(e.to));
                    end
                    m_drain = 0; m_low = 0; m_busy = 0;
                end
            end
        end
    end

    // One full sequence: ack at drain edge ack_k (0 = never), clr at edge clr_k,
    // extra requests at edges r1..r3, optional request on the done cycle.
    task automatic run_seq(input int len, input int ack_k, input int clr_k,
                           input int r1, input int r2, input int r3, input bit req_on_done);
        exp_t e;
        bit   to;
        bit   done_seen;
        int   d;
        to = (ack_k < 1) || (ack_k > DTO);
        d  = to ? DTO : ack_k;
        e.drain = d;
        e.low   = (len < MINA) ? MINA : len;
        e.busy  = d + e.low + SYNC_D + 1;
        if (to)                          to_model = 1'b1;
        else if (clr_k > 0 && clr_k <= d) to_model = 1'b0;
        e.to = to_model;
        sb.push_back(e);

        soft_rst_req = 1'b1;
        soft_rst_len = LEN_W'(len);
        @(posedge nvdla_clk); #1;
        soft_rst_req = 1'b0;
        done_seen = 1'b0;
        for (int k = 1; k <= 400 && !done_seen; k++) begin
            drain_ack    = (k == ack_k);
            timeout_clr  = (k == clr_k);
            soft_rst_req = (k == r1) || (k == r2) || (k == r3);
            @(posedge nvdla_clk); #1;
            done_seen = soft_rst_done;
        end
        drain_ack    = 1'b0;
        timeout_clr  = 1'b0;
        soft_rst_req = req_on_done;
        if (!done_seen) check("done_wait_expired", 0, 1);
        @(posedge nvdla_clk); #1;
        soft_rst_req = 1'b0;
    endtask

    task automatic pulse_clr();
        timeout_clr = 1'b1;
        @(posedge nvdla_clk); #1;
        timeout_clr = 1'b0;
        to_model = 1'b0;
        check("timeout_after_clr", int'(drain_timeout), 0);
    endtask

    initial begin
        dla_reset_rstn = 1'b0;
        soft_rst_req   = 1'b0;
        soft_rst_len   = '0;
        drain_ack      = 1'b0;
        timeout_clr    = 1'b0;

        #12;
        check("rst_core_rstn", int'(core_reset_rstn), 1);
        check("rst_drain_req", int'(drain_req), 0);
        check("rst_busy", int'(soft_rst_busy), 0);
        check("rst_done", int'(soft_rst_done), 0);
        check("rst_timeout", int'(drain_timeout), 0);
        #10;
        dla_reset_rstn = 1'b1;
        @(posedge nvdla_clk); #1;

        // Nominal and length clamp
        run_seq(10, 3, 0, 0, 0, 0, 1'b0);
        run_seq(0, 2, 0, 0, 0, 0, 1'b0);
        run_seq(2, 5, 0, 0, 0, 0, 1'b0);
        run_seq(255, 1, 0, 0, 0, 0, 1'b0);

        // Drain timeout, clear, and set-wins-over-clear
        run_seq(8, 0, 0, 0, 0, 0, 1'b0);
        pulse_clr();
        run_seq(4, 0, DTO, 0, 0, 0, 1'b0);
        pulse_clr();

        // Ack on the timeout edge
        run_seq(5, DTO, 0, 0, 0, 0, 1'b0);

        // Ignored requests in DRAIN/ASSERT/RELEASE and on the done cycle, then back-to-back
        run_seq(6, 3, 0, 2, 5, 12, 1'b1);
        run_seq(4, 2, 0, 0, 0, 0, 1'b0);

        // Asynchronous reset mid-ASSERT
        soft_rst_req = 1'b1;
        soft_rst_len = LEN_W'(20);
        @(posedge nvdla_clk); #1;
        soft_rst_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drain_ack = (k == 2);
            @(posedge nvdla_clk); #1;
        end
        drain_ack = 1'b0;
        check("pre_reset_core_rstn_low", int'(core_reset_rstn), 0);
        #2;
        dla_reset_rstn = 1'b0;
        #1;
        check("midrst_core_rstn", int'(core_reset_rstn), 1);
        check("midrst_drain_req", int'(drain_req), 0);
        check("midrst_busy", int'(soft_rst_busy), 0);
        check("midrst_done", int'(soft_rst_done), 0);
        repeat (2) @(posedge nvdla_clk);
        #3;
        dla_reset_rstn = 1'b1;
        @(posedge nvdla_clk); #1;
        repeat (40) @(posedge nvdla_clk);
        #1;
        check("post_reset_busy", int'(soft_rst_busy), 0);
        run_seq(7, 4, 0, 0, 0, 0, 1'b0);

        repeat (5) @(posedge nvdla_clk);
        check("pending_done_count", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_core_soft_reset_seq.md
Name: nv_nvdla_core_soft_reset_seq

Overview:
- Software-requested soft-reset sequencer for the NVDLA core.
- Produces core_reset_rstn, which feeds the core reset synchronizer/combiner.
- On a request, it first asks the datapath to drain, then pulses core_reset_rstn low for a programmed length.
- It then waits until the downstream synchronized reset (synced_rstn, fed back) has both asserted and released, and reports completion.

Parameters:
- LEN_W, 8: width of the soft_rst_len input.
- MIN_ASSERT, 4: minimum core_reset_rstn low time in cycles; shorter programmed lengths are clamped up to this.
- DRAIN_TIMEOUT, 4095: maximum cycles spent waiting for drain_ack (range 1..4095).
- TO_W, 12: width of the drain counter; must satisfy 2^TO_W > DRAIN_TIMEOUT.

Ports:
- nvdla_clk  in  1  core clock; the only clock.
- dla_reset_rstn  in  1  asynchronous, active-low reset.
- soft_rst_req  in  1  single-cycle soft-reset request pulse from a CSB register write.
- soft_rst_len  in  LEN_W  requested reset low time in cycles; sampled only when a request is accepted.
- drain_ack  in  1  datapath reports it is quiescent.
- synced_rstn  in  1  feedback from the downstream synchronized core reset.
- timeout_clr  in  1  clears drain_timeout.
- drain_req  out  1  request to the datapath to quiesce.
- core_reset_rstn  out  1  core reset request, active-low.
- soft_rst_busy  out  1  sequence in progress.
- soft_rst_done  out  1  single-cycle completion pulse.
- drain_timeout  out  1  sticky flag: drain was abandoned on timeout.

Behaviour:
- Clock and reset: one clock, nvdla_clk. Reset dla_reset_rstn is asynchronous, active-low. All outputs are registered.
- Values while dla_reset_rstn is low:
  - state = IDLE
  - core_reset_rstn = 1 (the core is already held by the dla reset path)
  - drain_req = 0, soft_rst_busy = 0, soft_rst_done = 0, drain_timeout = 0
  - all counters = 0
- Reset mid-sequence: returns immediately to these values. No done pulse is generated, and the partial sequence is discarded.
- States: IDLE, DRAIN, ASSERT, RELEASE, DONE.
- IDLE:
  - If soft_rst_req=1 at edge E0:
    - latch len = max(soft_rst_len, MIN_ASSERT), using an unsigned compare;
    - clear drain_cnt and seen_low;
    - go to DRAIN.
  - After E0: drain_req=1 and soft_rst_busy=1.
- DRAIN:
  - drain_cnt increments every cycle.
  - If drain_ack=1 at an edge: go to ASSERT.
  - Otherwise, if drain_cnt == DRAIN_TIMEOUT-1 at that edge: set drain_timeout and go to ASSERT anyway.
  - Net effect: drain_req is high for at most DRAIN_TIMEOUT cycles.
  - If ack and the timeout condition occur on the same edge, ack wins and drain_timeout is not set.
- ASSERT:
  - On entry: drain_req=0 and core_reset_rstn=0.
  - core_reset_rstn stays low for exactly len cycles, counted by a down-counter loaded with len on entry.
  - When the counter expires: go to RELEASE with core_reset_rstn=1.
- seen_low: set on any edge in ASSERT or RELEASE where synced_rstn=0.
- RELEASE:
  - Leave when seen_low=1 and synced_rstn=1 are sampled on the same edge; go to DONE.
  - There is no timeout in this state; the downstream synchronizer release is guaranteed.
- DONE:
  - soft_rst_done=1 for exactly one cycle, and soft_rst_busy=0 in that same cycle.
  - Next edge: IDLE.
- Requests while busy:
  - soft_rst_req in any non-IDLE state is ignored (dropped, not queued).
  - A request on the cycle soft_rst_done=1 is also ignored, because the state is still DONE.
  - A request is accepted from the following cycle.
- drain_timeout:
  - Sticky until timeout_clr=1.
  - If set and clear occur on the same edge, set wins.
- drain_ack outside DRAIN is ignored. synced_rstn outside ASSERT/RELEASE is ignored.

Test Plan:
Bench uses DRAIN_TIMEOUT=16, MIN_ASSERT=4, and a downstream model where synced_rstn follows core_reset_rstn with 6 cycles of delay on both edges.
1. Nominal sequence:
   - Stimulus: req at E0 with len=10; drain_ack raised at E3.
   - Response: drain_req high cycles 1–3; core_reset_rstn low cycles 4–13; soft_rst_done pulses 1 cycle after synced_rstn returns high; busy high cycle 1 until done.
2. Length clamp:
   - Stimulus: len=0, then len=2.
   - Response: core_reset_rstn low exactly 4 cycles in each run. Stimulus len=255 -> low 255 cycles.
3. Drain timeout:
   - Stimulus: drain_ack never asserted.
   - Response: drain_req high exactly 16 cycles; drain_timeout=1; sequence still completes with done.
   - Follow-up: timeout_clr -> flag 0. Timeout and clr on the same edge -> flag remains 1.
4. Ack coincident with timeout:
   - Stimulus: drain_ack=1 on the 16th drain edge.
   - Response: ASSERT entered; drain_timeout stays 0.
5. Busy and back-to-back requests:
   - Stimulus: extra req pulses during DRAIN/ASSERT/RELEASE, and on the done cycle.
   - Response: all are ignored, exactly one done pulse. A req one cycle after done starts a new sequence.
6. Reset mid-ASSERT:
   - Stimulus: dla_reset_rstn pulled low asynchronously mid-ASSERT.
   - Response: immediately core_reset_rstn=1, drain_req=0, busy=0, and no done pulse.
   - After release: state is IDLE and a new req is accepted.
